pic_cmd_sequencer: RTL and testbench
====================================

Name: pic_cmd_sequencer

Overview:
- Command/initialization controller for the 8259A-compatible PIC.
- Decodes CPU writes into the ICW1–ICW4 initialization sequence and the OCW1–OCW3 operational commands.
- Drives the static configuration (LTIM, SFNM, AEOI, AR, TReg, IMR, read selects) and the one-cycle command pulses (EOI, rotate, poll) consumed by the interrupt logic block.
- Sits between the CPU bus interface and the interrupt logic.

Parameters:
- RESET_IMR, 8'h00, IMR value after reset and after every ICW1.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_n  in  1  synchronous active-low reset.
- CS  in  1  chip select, active high, synchronous to CLK.
- WR  in  1  write strobe; one write per cycle where CS&WR=1.
- A0  in  1  address bit of the write.
- D  in  8  write data.
- LTIM  out  1  level-triggered mode (ICW1.D3).
- SNGL  out  1  single mode (ICW1.D1).
- SFNM  out  1  special fully nested mode (ICW4.D4).
- AEOI  out  1  automatic EOI (ICW4.D1).
- AR  out  1  automatic rotation enable (set/cleared by OCW2).
- TReg  out  5  vector base T7–T3 (ICW2.D7:D3).
- ICW3  out  8  cascade byte.
- IMR  out  8  interrupt mask register (OCW1).
- readIRR  out  1  status read selects IRR.
- readISR  out  1  status read selects ISR.
- SMM  out  1  special mask mode.
- eoiPulse  out  1  EOI command, 1-cycle pulse.
- eoiSpecific  out  1  valid with eoiPulse; 1 = specific level.
- rotatePulse  out  1  rotate command, 1-cycle pulse.
- setPriPulse  out  1  set-priority command, 1-cycle pulse.
- level  out  3  L2–L0 of the last OCW2; held until the next OCW2.
- pollPulse  out  1  poll command (OCW3.P), 1-cycle pulse.
- initDone  out  1  initialization complete, OCWs accepted.

Behaviour:
- Write event: CS&WR sampled high at a rising edge. Outputs update on that same edge, so they are visible the following cycle. Pulses last exactly one cycle. Non-write cycles clear all pulses.
- Reset (RST_n=0 at edge):
  - state=IDLE; initDone=0.
  - LTIM=SNGL=SFNM=AEOI=AR=SMM=0; TReg=0; ICW3=0; IMR=RESET_IMR.
  - readIRR=1, readISR=0; level=0; all pulses 0.
  - Reset overrides a simultaneous write.
- ICW1 (A0=0, D4=1) in any state:
  - Restarts initialization: initDone=0, IMR=RESET_IMR, readIRR=1, readISR=0, SMM=0, AR=0, AEOI=0, SFNM=0.
  - Latches LTIM=D3, SNGL=D1, IC4=D0 (internal). State → WAIT_ICW2.
- State machine IDLE/WAIT_ICW2/WAIT_ICW3/WAIT_ICW4/READY:
  - WAIT_ICW2, A0=1 write: TReg=D[7:3]. Next state WAIT_ICW3 if SNGL=0; else WAIT_ICW4 if IC4=1; else READY.
  - WAIT_ICW3, A0=1 write: ICW3=D. Next WAIT_ICW4 if IC4 else READY.
  - WAIT_ICW4, A0=1 write: AEOI=D1, SFNM=D4. Next READY.
  - Entering READY sets initDone=1.
  - In WAIT_* states, A0=0 writes with D4=0 are ignored; no state change, no pulses.
  - In IDLE, all writes other than ICW1 are ignored.
- READY, A0=1: OCW1, IMR=D.
- READY, A0=0, D4=0, D3=0: OCW2; level=D[2:0]. Action by code {R,SL,EOI}=D[7:5]:
  - 001: eoiPulse, eoiSpecific=0.
  - 011: eoiPulse, eoiSpecific=1.
  - 101: eoiPulse + rotatePulse, eoiSpecific=0.
  - 111: eoiPulse + rotatePulse, eoiSpecific=1.
  - 100: AR=1.
  - 000: AR=0.
  - 110: setPriPulse.
  - 010: no operation.
- READY, A0=0, D4=0, D3=1: OCW3.
  - If D1=1: readIRR=~D0, readISR=D0. If D1=0, read selects are unchanged.
  - If D6=1: SMM=D5.
  - If D2=1: pollPulse.
  - The poll pulse and read-select update may occur in the same write.
- Back-to-back writes on consecutive cycles are each processed. Pulses on consecutive cycles are allowed.

Decomposition:
- Shared package pic_pkg holds:
  - state enum (IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY);
  - OCW2 code constants (OCW2_NS_EOI=3'b001, OCW2_SP_EOI=3'b011, OCW2_ROT_NS=3'b101, OCW2_ROT_SP=3'b111, OCW2_SET_AR=3'b100, OCW2_CLR_AR=3'b000, OCW2_SET_PRI=3'b110);
  - ICW/OCW bit-position constants.
- One sub-module is natural: pic_ocw_decode, a combinational OCW2/OCW3 field decode feeding the registered sequencer.

Test Plan:
- Reset, then ICW1=8'h13, ICW2=8'h20 → after ICW2: TReg=5'b00100, SNGL=1, initDone=0, state WAIT_ICW4. Then ICW4=8'h02 → AEOI=1, SFNM=0, initDone=1.
- ICW1=8'h18 (cascade, no IC4), ICW2=8'h48, ICW3=8'h04 → LTIM=1, TReg=5'b01001, ICW3=8'h04, initDone=1 with no ICW4 write.
- After init: OCW1=8'hA5 → IMR=8'hA5. OCW2=8'h63 → one-cycle eoiPulse with eoiSpecific=1, level=3. OCW2=8'hA0 → eoiPulse and rotatePulse both high the same cycle.
- OCW2=8'h80 → AR=1. OCW3=8'h0B → readISR=1, readIRR=0. OCW3=8'h0C → pollPulse, read selects unchanged. OCW3=8'h68 → SMM=1.
- ICW1=8'h13 issued while in WAIT_ICW3 of another sequence → state WAIT_ICW2, IMR=8'h00, readIRR=1, initDone=0. An A0=0/D4=0 write in WAIT_ICW2 produces no change.
- RST_n low coincident with a CS&WR OCW1 write of 8'hFF → IMR=RESET_IMR, state IDLE. A subsequent OCW1 write before any ICW1 is ignored.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-compatible PIC command path.
// Holds the init sequencer state enum, OCW2 command codes and ICW/OCW bit positions.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } pic_state_e;

  // OCW2 {R,SL,EOI} command codes
  localparam logic [2:0] OCW2_NS_EOI  = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI  = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS  = 3'b101;
  localparam logic [2:0] OCW2_ROT_SP  = 3'b111;
  localparam logic [2:0] OCW2_SET_AR  = 3'b100;
  localparam logic [2:0] OCW2_CLR_AR  = 3'b000;
  localparam logic [2:0] OCW2_SET_PRI = 3'b110;

  localparam int ICW1_IC4   = 0;
  localparam int ICW1_SNGL  = 1;
  localparam int ICW1_LTIM  = 3;
  localparam int CMD_ICW1   = 4;
  localparam int OCW_SEL    = 3;
  localparam int ICW4_AEOI  = 1;
  localparam int ICW4_SFNM  = 4;
  localparam int OCW3_RIS   = 0;
  localparam int OCW3_RR    = 1;
  localparam int OCW3_P     = 2;
  localparam int OCW3_SMM   = 5;
  localparam int OCW3_ESMM  = 6;

  function automatic logic is_icw1(input logic a0, input logic [7:0] d);
    return (!a0) && d[CMD_ICW1];
  endfunction

endpackage

// File: rtl/pic_ocw_decode.sv
// Combinational field decode of an A0=0 data byte into OCW2/OCW3 actions.
// The sequencer qualifies these with the write strobe and its READY state.
module pic_ocw_decode
  import pic_pkg::*;
(
  input  logic [7:0] d,
  output logic       ocw2_sel_s,
  output logic       ocw3_sel_s,
  output logic [2:0] level_s,
  output logic       eoi_s,
  output logic       eoi_specific_s,
  output logic       rotate_s,
  output logic       set_pri_s,
  output logic       set_ar_s,
  output logic       clr_ar_s,
  output logic       rd_update_s,
  output logic       rd_isr_s,
  output logic       smm_update_s,
  output logic       smm_val_s,
  output logic       poll_s
);

  assign ocw2_sel_s   = (!d[CMD_ICW1]) && (!d[OCW_SEL]);
  assign ocw3_sel_s   = (!d[CMD_ICW1]) && d[OCW_SEL];
  assign level_s      = d[2:0];
  assign rd_update_s  = d[OCW3_RR];
  assign rd_isr_s     = d[OCW3_RIS];
  assign smm_update_s = d[OCW3_ESMM];
  assign smm_val_s    = d[OCW3_SMM];
  assign poll_s       = d[OCW3_P];

  // OCW2 {R,SL,EOI} command decode
  always_comb begin
    eoi_s          = 1'b0;
    eoi_specific_s = 1'b0;
    rotate_s       = 1'b0;
    set_pri_s      = 1'b0;
    set_ar_s       = 1'b0;
    clr_ar_s       = 1'b0;
    case (d[7:5])
      OCW2_NS_EOI:  eoi_s = 1'b1;
      OCW2_SP_EOI:  begin eoi_s = 1'b1; eoi_specific_s = 1'b1; end
      OCW2_ROT_NS:  begin eoi_s = 1'b1; rotate_s = 1'b1; end
      OCW2_ROT_SP:  begin eoi_s = 1'b1; rotate_s = 1'b1; eoi_specific_s = 1'b1; end
      OCW2_SET_AR:  set_ar_s = 1'b1;
      OCW2_CLR_AR:  clr_ar_s = 1'b1;
      OCW2_SET_PRI: set_pri_s = 1'b1;
      default:      eoi_s = 1'b0;
    endcase
  end

endmodule

// File: rtl/pic_cmd_sequencer.sv
// 8259A-compatible command/initialization sequencer: tracks ICW1-ICW4, applies
// OCW1-OCW3 once initialized, and registers all configuration and command pulses.
module pic_cmd_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] RESET_IMR = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       CS,
  input  logic       WR,
  input  logic       A0,
  input  logic [7:0] D,
  output logic       LTIM,
  output logic       SNGL,
  output logic       SFNM,
  output logic       AEOI,
  output logic       AR,
  output logic [4:0] TReg,
  output logic [7:0] ICW3,
  output logic [7:0] IMR,
  output logic       readIRR,
  output logic       readISR,
  output logic       SMM,
  output logic       eoiPulse,
  output logic       eoiSpecific,
  output logic       rotatePulse,
  output logic       setPriPulse,
  output logic [2:0] level,
  output logic       pollPulse,
  output logic       initDone
);

  pic_state_e state_r, state_nxt;
  logic ic4_r, ic4_nxt, ltim_r, ltim_nxt, sngl_r, sngl_nxt, sfnm_r, sfnm_nxt;
  logic aeoi_r, aeoi_nxt, ar_r, ar_nxt, rirr_r, rirr_nxt, risr_r, risr_nxt;
  logic smm_r, smm_nxt, init_r, init_nxt;
  logic eoi_r, eoi_nxt, eoi_sp_r, eoi_sp_nxt, rot_r, rot_nxt;
  logic setpri_r, setpri_nxt, poll_r, poll_nxt;
  logic [4:0] treg_r, treg_nxt;
  logic [7:0] icw3_r, icw3_nxt, imr_r, imr_nxt;
  logic [2:0] level_r, level_nxt;

  logic wr_s;
  logic ocw2_sel_s, ocw3_sel_s, dec_eoi_s, dec_eoi_sp_s, dec_rot_s, dec_setpri_s;
  logic dec_set_ar_s, dec_clr_ar_s, dec_rd_upd_s, dec_rd_isr_s;
  logic dec_smm_upd_s, dec_smm_val_s, dec_poll_s;
  logic [2:0] dec_level_s;

  assign wr_s = CS & WR;

  pic_ocw_decode u_ocw_decode (
    .d              (D),
    .ocw2_sel_s     (ocw2_sel_s),
    .ocw3_sel_s     (ocw3_sel_s),
    .level_s        (dec_level_s),
    .eoi_s          (dec_eoi_s),
    .eoi_specific_s (dec_eoi_sp_s),
    .rotate_s       (dec_rot_s),
    .set_pri_s      (dec_setpri_s),
    .set_ar_s       (dec_set_ar_s),
    .clr_ar_s       (dec_clr_ar_s),
    .rd_update_s    (dec_rd_upd_s),
    .rd_isr_s       (dec_rd_isr_s),
    .smm_update_s   (dec_smm_upd_s),
    .smm_val_s      (dec_smm_val_s),
    .poll_s         (dec_poll_s)
  );

  // Next-state and next-register computation; pulses default low every cycle
  always_comb begin
    state_nxt  = state_r;   ic4_nxt  = ic4_r;   ltim_nxt = ltim_r;  sngl_nxt = sngl_r;
    sfnm_nxt   = sfnm_r;    aeoi_nxt = aeoi_r;  ar_nxt   = ar_r;    rirr_nxt = rirr_r;
    risr_nxt   = risr_r;    smm_nxt  = smm_r;   init_nxt = init_r;  treg_nxt = treg_r;
    icw3_nxt   = icw3_r;    imr_nxt  = imr_r;   level_nxt = level_r;
    eoi_nxt    = 1'b0;      eoi_sp_nxt = 1'b0;  rot_nxt  = 1'b0;
    setpri_nxt = 1'b0;      poll_nxt = 1'b0;
    if (wr_s && is_icw1(A0, D)) begin
      state_nxt = WAIT_ICW2;
      init_nxt  = 1'b0;
      imr_nxt   = RESET_IMR;
      rirr_nxt  = 1'b1;
      risr_nxt  = 1'b0;
      smm_nxt   = 1'b0;
      ar_nxt    = 1'b0;
      aeoi_nxt  = 1'b0;
      sfnm_nxt  = 1'b0;
      ltim_nxt  = D[ICW1_LTIM];
      sngl_nxt  = D[ICW1_SNGL];
      ic4_nxt   = D[ICW1_IC4];
    end else if (wr_s) begin
      case (state_r)
        IDLE: state_nxt = IDLE;
        WAIT_ICW2: begin
          if (A0) begin
            treg_nxt = D[7:3];
            if (!sngl_r) begin
              state_nxt = WAIT_ICW3;
            end else if (ic4_r) begin
              state_nxt = WAIT_ICW4;
            end else begin
              state_nxt = READY;
              init_nxt  = 1'b1;
            end
          end else begin
            state_nxt = WAIT_ICW2;
          end
        end
        WAIT_ICW3: begin
          if (A0) begin
            icw3_nxt = D;
            if (ic4_r) begin
              state_nxt = WAIT_ICW4;
            end else begin
              state_nxt = READY;
              init_nxt  = 1'b1;
            end
          end else begin
            state_nxt = WAIT_ICW3;
          end
        end
        WAIT_ICW4: begin
          if (A0) begin
            aeoi_nxt  = D[ICW4_AEOI];
            sfnm_nxt  = D[ICW4_SFNM];
            state_nxt = READY;
            init_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_ICW4;
          end
        end
        READY: begin
          if (A0) begin
            imr_nxt = D;
          end else if (ocw2_sel_s) begin
            level_nxt  = dec_level_s;
            eoi_nxt    = dec_eoi_s;
            eoi_sp_nxt = dec_eoi_sp_s;
            rot_nxt    = dec_rot_s;
            setpri_nxt = dec_setpri_s;
            if (dec_set_ar_s) begin
              ar_nxt = 1'b1;
            end else if (dec_clr_ar_s) begin
              ar_nxt = 1'b0;
            end else begin
              ar_nxt = ar_r;
            end
          end else if (ocw3_sel_s) begin
            poll_nxt = dec_poll_s;
            if (dec_rd_upd_s) begin
              rirr_nxt = ~dec_rd_isr_s;
              risr_nxt = dec_rd_isr_s;
            end else begin
              rirr_nxt = rirr_r;
            end
            if (dec_smm_upd_s) begin
              smm_nxt = dec_smm_val_s;
            end else begin
              smm_nxt = smm_r;
            end
          end else begin
            state_nxt = READY;
          end
        end
        default: begin
          state_nxt = IDLE;
          init_nxt  = 1'b0;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Configuration and pulse registers
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      ic4_r  <= 1'b0; ltim_r <= 1'b0; sngl_r <= 1'b0; sfnm_r <= 1'b0;
      aeoi_r <= 1'b0; ar_r   <= 1'b0; rirr_r <= 1'b1; risr_r <= 1'b0;
      smm_r  <= 1'b0; init_r <= 1'b0; treg_r <= 5'd0; icw3_r <= 8'h00;
      imr_r  <= RESET_IMR; level_r <= 3'd0;
      eoi_r  <= 1'b0; eoi_sp_r <= 1'b0; rot_r <= 1'b0; setpri_r <= 1'b0; poll_r <= 1'b0;
    end else begin
      ic4_r  <= ic4_nxt;  ltim_r <= ltim_nxt; sngl_r <= sngl_nxt; sfnm_r <= sfnm_nxt;
      aeoi_r <= aeoi_nxt; ar_r   <= ar_nxt;   rirr_r <= rirr_nxt; risr_r <= risr_nxt;
      smm_r  <= smm_nxt;  init_r <= init_nxt; treg_r <= treg_nxt; icw3_r <= icw3_nxt;
      imr_r  <= imr_nxt;  level_r <= level_nxt;
      eoi_r  <= eoi_nxt;  eoi_sp_r <= eoi_sp_nxt; rot_r <= rot_nxt;
      setpri_r <= setpri_nxt; poll_r <= poll_nxt;
    end
  end

  assign LTIM        = ltim_r;
  assign SNGL        = sngl_r;
  assign SFNM        = sfnm_r;
  assign AEOI        = aeoi_r;
  assign AR          = ar_r;
  assign TReg        = treg_r;
  assign ICW3        = icw3_r;
  assign IMR         = imr_r;
  assign readIRR     = rirr_r;
  assign readISR     = risr_r;
  assign SMM         = smm_r;
  assign eoiPulse    = eoi_r;
  assign eoiSpecific = eoi_sp_r;
  assign rotatePulse = rot_r;
  assign setPriPulse = setpri_r;
  assign level       = level_r;
  assign pollPulse   = poll_r;
  assign initDone    = init_r;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Testbench for pic_cmd_sequencer: directed init/command steps, then random
// traffic, both checked against a queue-based behavioural model of the PIC.
module tb_pic_cmd_sequencer;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0, CS = 1'b0, WR = 1'b0, A0 = 1'b0;
  logic [7:0] D = 8'h00;
  logic       LTIM, SNGL, SFNM, AEOI, AR, readIRR, readISR, SMM;
  logic       eoiPulse, eoiSpecific, rotatePulse, setPriPulse, pollPulse, initDone;
  logic [4:0] TReg;
  logic [7:0] ICW3, IMR;
  logic [2:0] level;

  pic_cmd_sequencer #(.RESET_IMR(8'h00)) dut (
    .CLK(CLK), .RST_n(RST_n), .CS(CS), .WR(WR), .A0(A0), .D(D),
    .LTIM(LTIM), .SNGL(SNGL), .SFNM(SFNM), .AEOI(AEOI), .AR(AR), .TReg(TReg),
    .ICW3(ICW3), .IMR(IMR), .readIRR(readIRR), .readISR(readISR), .SMM(SMM),
    .eoiPulse(eoiPulse), .eoiSpecific(eoiSpecific), .rotatePulse(rotatePulse),
    .setPriPulse(setPriPulse), .level(level), .pollPulse(pollPulse), .initDone(initDone)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: pending lists the ICW words (2/3/4) still owed after an ICW1.
  int         pending[$];
  logic       m_init, m_ic4, m_ltim, m_sngl, m_sfnm, m_aeoi, m_ar, m_rirr, m_risr, m_smm;
  logic       m_eoi, m_eoisp, m_rot, m_setpri, m_poll;
  logic [4:0] m_treg;
  logic [7:0] m_icw3, m_imr;
  logic [2:0] m_level;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic cs, input logic wr,
                            input logic a0, input logic [7:0] d);
    int w;
    m_eoi = 1'b0; m_eoisp = 1'b0; m_rot = 1'b0; m_setpri = 1'b0; m_poll = 1'b0;
    if (!rst) begin
      pending.delete();
      m_init = 1'b0; m_ic4 = 1'b0; m_ltim = 1'b0; m_sngl = 1'b0; m_sfnm = 1'b0;
      m_aeoi = 1'b0; m_ar = 1'b0; m_rirr = 1'b1; m_risr = 1'b0; m_smm = 1'b0;
      m_treg = 5'd0; m_icw3 = 8'h00; m_imr = 8'h00; m_level = 3'd0;
    end else if (cs && wr) begin
      if (!a0 && d[4]) begin
        m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
        m_init = 1'b0; m_imr = 8'h00; m_rirr = 1'b1; m_risr = 1'b0;
        m_smm = 1'b0; m_ar = 1'b0; m_aeoi = 1'b0; m_sfnm = 1'b0;
        pending.delete();
        pending.push_back(2);
        if (!m_sngl) pending.push_back(3);
        if (m_ic4) pending.push_back(4);
      end else if (pending.size() > 0) begin
        if (a0) begin
          w = pending.pop_front();
          if (w == 2) m_treg = d[7:3];
          else if (w == 3) m_icw3 = d;
          else begin m_aeoi = d[1]; m_sfnm = d[4]; end
          if (pending.size() == 0) m_init = 1'b1;
        end
      end else if (m_init) begin
        if (a0) m_imr = d;
        else if (!d[3]) begin
          m_level = d[2:0];
          if (d[5]) begin
            m_eoi = 1'b1; m_eoisp = d[6]; m_rot = d[7];
          end else if (d[7] && !d[6]) m_ar = 1'b1;
          else if (!d[7] && !d[6]) m_ar = 1'b0;
          else if (d[7] && d[6]) m_setpri = 1'b1;
        end else begin
          if (d[1]) begin m_rirr = ~d[0]; m_risr = d[0]; end
          if (d[6]) m_smm = d[5];
          m_poll = d[2];
        end
      end
    end
  endtask

  task automatic check_all();
    chk("LTIM", LTIM, m_ltim);       chk("SNGL", SNGL, m_sngl);
    chk("SFNM", SFNM, m_sfnm);       chk("AEOI", AEOI, m_aeoi);
    chk("AR", AR, m_ar);             chk("TReg", TReg, m_treg);
    chk("ICW3", ICW3, m_icw3);       chk("IMR", IMR, m_imr);
    chk("readIRR", readIRR, m_rirr); chk("readISR", readISR, m_risr);
    chk("SMM", SMM, m_smm);          chk("eoiPulse", eoiPulse, m_eoi);
    chk("rotatePulse", rotatePulse, m_rot);
    chk("setPriPulse", setPriPulse, m_setpri);
    chk("pollPulse", pollPulse, m_poll);
    chk("level", level, m_level);    chk("initDone", initDone, m_init);
    if (m_eoi) chk("eoiSpecific", eoiSpecific, m_eoisp);
  endtask

  task automatic step(input logic rst, input logic cs, input logic wr,
                      input logic a0, input logic [7:0] d);
    RST_n = rst; CS = cs; WR = wr; A0 = a0; D = d;
    @(posedge CLK);
    model_edge(rst, cs, wr, a0, d);
    @(negedge CLK);
    check_all();
  endtask

  task automatic wr_cmd(input logic a0, input logic [7:0] d);
    step(1'b1, 1'b1, 1'b1, a0, d);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    int r;
    int k;
    logic a0;
    logic [7:0] d;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_IMR", IMR, 8'h00); chk("rst_readIRR", readIRR, 1'b1);
    chk("rst_initDone", initDone, 1'b0);

    // Single mode with ICW4
    wr_cmd(1'b0, 8'h13); wr_cmd(1'b1, 8'h20);
    chk("icw2_TReg", TReg, 5'b00100); chk("icw2_SNGL", SNGL, 1'b1);
    chk("icw2_initDone", initDone, 1'b0);
    wr_cmd(1'b1, 8'h02);
    chk("icw4_AEOI", AEOI, 1'b1); chk("icw4_SFNM", SFNM, 1'b0);
    chk("icw4_initDone", initDone, 1'b1);

    // Cascade, no ICW4
    wr_cmd(1'b0, 8'h18); wr_cmd(1'b1, 8'h48); wr_cmd(1'b1, 8'h04);
    chk("casc_LTIM", LTIM, 1'b1); chk("casc_TReg", TReg, 5'b01001);
    chk("casc_ICW3", ICW3, 8'h04); chk("casc_initDone", initDone, 1'b1);

    // Operational commands
    wr_cmd(1'b1, 8'hA5); chk("ocw1_IMR", IMR, 8'hA5);
    wr_cmd(1'b0, 8'h63);
    chk("speoi_pulse", eoiPulse, 1'b1); chk("speoi_spec", eoiSpecific, 1'b1);
    chk("speoi_level", level, 3'd3);
    idle(); chk("eoi_cleared", eoiPulse, 1'b0); chk("level_held", level, 3'd3);
    wr_cmd(1'b0, 8'hA0);
    chk("rot_eoi", eoiPulse, 1'b1); chk("rot_pulse", rotatePulse, 1'b1);
    wr_cmd(1'b0, 8'h80); chk("set_AR", AR, 1'b1);
    wr_cmd(1'b0, 8'h0B); chk("ocw3_ISR", readISR, 1'b1); chk("ocw3_IRR", readIRR, 1'b0);
    wr_cmd(1'b0, 8'h0C); chk("poll", pollPulse, 1'b1); chk("poll_ISR_kept", readISR, 1'b1);
    wr_cmd(1'b0, 8'h68); chk("smm", SMM, 1'b1);
    wr_cmd(1'b0, 8'hC2); chk("setpri", setPriPulse, 1'b1);

    // ICW1 restart from WAIT_ICW3 of another sequence
    wr_cmd(1'b0, 8'h10); wr_cmd(1'b1, 8'h08);
    wr_cmd(1'b0, 8'h13);
    chk("restart_initDone", initDone, 1'b0); chk("restart_IMR", IMR, 8'h00);
    chk("restart_readIRR", readIRR, 1'b1);
    wr_cmd(1'b0, 8'h05); chk("w2_ignore_pulse", eoiPulse, 1'b0);
    wr_cmd(1'b1, 8'h20); wr_cmd(1'b1, 8'h00);
    chk("restart_done", initDone, 1'b1);

    // Reset coincident with a write, then OCW1 before any ICW1
    wr_cmd(1'b1, 8'h3C);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
    chk("rstwr_IMR", IMR, 8'h00); chk("rstwr_initDone", initDone, 1'b0);
    wr_cmd(1'b1, 8'h77); chk("idle_ocw1_ignored", IMR, 8'h00);

    // Randomized traffic, back-to-back writes included
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 9);
      d = 8'($urandom);
      if (k == 0) begin a0 = 1'b0; d = d | 8'h10; end
      else if (k <= 4) a0 = 1'b1;
      else begin a0 = 1'b0; d = d & 8'hEF; end
      if (r < 2) step(1'b0, 1'b1, 1'b1, a0, d);
      else if (r < 25) step(1'b1, 1'($urandom), 1'b0, a0, d);
      else wr_cmd(a0, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
